// File: rtl/bbox_sample_iterator_pkg.sv
// Shared raster definitions for the bounding-box sample iterator: sweep states,
// sub-sample one-hot codes and the grid step they select.
package bbox_sample_iterator_pkg;

  typedef enum logic {
    WAIT_STATE = 1'b0,
    TEST_STATE = 1'b1
  } iter_state_t;

  localparam logic [3:0] SS_1SPP  = 4'b1000;
  localparam logic [3:0] SS_4SPP  = 4'b0100;
  localparam logic [3:0] SS_16SPP = 4'b0010;
  localparam logic [3:0] SS_64SPP = 4'b0001;

  // Anything that is not a recognised one-hot code falls back to one sample per pixel.
  function automatic int unsigned ss_step(input logic [3:0] sub_sample, input int radix);
    case (sub_sample)
      SS_4SPP:  return 32'd1 << (radix - 1);
      SS_16SPP: return 32'd1 << (radix - 2);
      SS_64SPP: return 32'd1 << (radix - 3);
      default:  return 32'd1 << radix;
    endcase
  endfunction

endpackage

// File: rtl/bbox_sample_iterator.sv
// Walks a triangle's bounding box in raster order on the sub-sample grid, one
// sample per cycle, holding the triangle and colour alongside for the sample test.
module bbox_sample_iterator
  import bbox_sample_iterator_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
  input  logic [COLORS-1:0][SIGFIG-1:0]            color_R14U,
  input  logic [1:0][1:0][SIGFIG-1:0]              box_R14S,
  input  logic                                     validTri_R14H,
  input  logic [3:0]                               subSample_RnnnnU,
  output logic                                     halt_RnnnnH,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R16S,
  output logic [COLORS-1:0][SIGFIG-1:0]            color_R16U,
  output logic [1:0][SIGFIG-1:0]                   sample_R16S,
  output logic                                     validSamp_R16H
);

  iter_state_t state_reg, state_next;

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_reg, tri_next;
  logic [COLORS-1:0][SIGFIG-1:0]          color_reg, color_next;
  logic [SIGFIG-1:0] ll_x_reg, ll_x_next, ur_x_reg, ur_x_next;
  logic [SIGFIG-1:0] ur_y_reg, ur_y_next;
  logic [SIGFIG-1:0] x_reg, x_next, y_reg, y_next;
  logic [SIGFIG-1:0] step_reg, step_next;

  logic [SIGFIG-1:0]        step_in;
  logic signed [SIGFIG:0]   x_adv, y_adv;
  logic                     fits_x, fits_y, is_last, box_ok, accept;

  assign step_in = SIGFIG'(ss_step(subSample_RnnnnU, RADIX));

  // Advance and compare one bit wider than the coordinates so a step past the
  // top of the signed range still reads as "beyond ur" and the sweep ends.
  always_comb begin
    state_next = state_reg;
    tri_next   = tri_reg;
    color_next = color_reg;
    ll_x_next  = ll_x_reg;
    ur_x_next  = ur_x_reg;
    ur_y_next  = ur_y_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    step_next  = step_reg;

    x_adv  = $signed({x_reg[SIGFIG-1], x_reg}) + $signed({1'b0, step_reg});
    y_adv  = $signed({y_reg[SIGFIG-1], y_reg}) + $signed({1'b0, step_reg});
    fits_x = x_adv <= $signed({ur_x_reg[SIGFIG-1], ur_x_reg});
    fits_y = y_adv <= $signed({ur_y_reg[SIGFIG-1], ur_y_reg});
    is_last = (state_reg == TEST_STATE) && !fits_x && !fits_y;

    box_ok = ($signed(box_R14S[0][0]) <= $signed(box_R14S[1][0])) &&
             ($signed(box_R14S[0][1]) <= $signed(box_R14S[1][1]));
    accept = validTri_R14H && ((state_reg == WAIT_STATE) || is_last);

    if (accept) begin
      if (box_ok) begin
        state_next = TEST_STATE;
        tri_next   = tri_R14S;
        color_next = color_R14U;
        ll_x_next  = box_R14S[0][0];
        ur_x_next  = box_R14S[1][0];
        ur_y_next  = box_R14S[1][1];
        x_next     = box_R14S[0][0];
        y_next     = box_R14S[0][1];
        step_next  = step_in;
      end else begin
        // Degenerate box: handshake completes but nothing is swept.
        state_next = WAIT_STATE;
      end
    end else if (state_reg == TEST_STATE) begin
      if (fits_x) begin
        x_next = x_adv[SIGFIG-1:0];
      end else if (fits_y) begin
        x_next = ll_x_reg;
        y_next = y_adv[SIGFIG-1:0];
      end else begin
        state_next = WAIT_STATE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= WAIT_STATE;
      tri_reg   <= '0;
      color_reg <= '0;
      ll_x_reg  <= '0;
      ur_x_reg  <= '0;
      ur_y_reg  <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      tri_reg   <= tri_next;
      color_reg <= color_next;
      ll_x_reg  <= ll_x_next;
      ur_x_reg  <= ur_x_next;
      ur_y_reg  <= ur_y_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      step_reg  <= step_next;
    end
  end

  always_comb begin
    halt_RnnnnH    = (state_reg == WAIT_STATE) || is_last;
    validSamp_R16H = (state_reg == TEST_STATE);
    sample_R16S    = {y_reg, x_reg};
    tri_R16S       = tri_reg;
    color_R16U     = color_reg;
  end

endmodule
